// File: rtl/dmem_wb_responder_if.sv
// Wishbone-classic bus bundle between the mox125 data port (master)
// and the on-chip data memory responder (slave).
interface dmem_wb_responder_if;
    logic [31:0] wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/dmem_wb_responder.sv
// 16-bit Wishbone-classic data memory with byte-lane writes, a programmable
// number of wait states before termination, and an error termination for
// addresses outside the memory window.
module dmem_wb_responder #(
    parameter int          DEPTH_LOG2  = 12,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    dmem_wb_responder_if.slave  wb
);

    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    // Window limit is computed one bit wider so a window ending at the top
    // of the 32-bit space does not wrap to zero.
    localparam logic [32:0] WIN_BYTES = 33'd1 << (DEPTH_LOG2 + 1);
    localparam logic [32:0] WIN_LIMIT = {1'b0, BASE_ADDR} + WIN_BYTES;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_TERM
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [3:0]             wait_cnt;
    logic [3:0]             wait_cnt_next;
    logic                   do_access;
    logic                   req_valid;
    logic                   in_range;
    logic [DEPTH_LOG2-1:0]  word_idx;
    logic                   ack;
    logic                   err;
    logic [15:0]            rdata;
    logic [15:0]            mem [DEPTH];

    assign req_valid = wb.wb_cyc_i & wb.wb_stb_i;
    assign in_range  = ({1'b0, wb.wb_adr_i} >= {1'b0, BASE_ADDR}) &&
                       ({1'b0, wb.wb_adr_i} <  WIN_LIMIT);
    // BASE_ADDR is window-aligned, so the word index is just the address
    // bits inside the window minus the (zero) base bits there.
    assign word_idx  = wb.wb_adr_i[DEPTH_LOG2:1] - BASE_ADDR[DEPTH_LOG2:1];

    // Next-state logic: decides when the access happens and when to terminate.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        state_next    = state;
        wait_cnt_next = wait_cnt;
        do_access     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    wait_cnt_next = WAIT_LOAD;
                    if (WAIT_LOAD == 4'd0) begin
                        do_access  = 1'b1;
                        state_next = ST_TERM;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                wait_cnt_next = wait_cnt - 4'd1;
                if (!req_valid) begin
                    state_next = ST_IDLE;
                end else if (wait_cnt == 4'd1) begin
                    do_access  = 1'b1;
                    state_next = ST_TERM;
                end
            end
            ST_TERM: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, counter, termination pulses and read-data register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            ack      <= 1'b0;
            err      <= 1'b0;
            rdata    <= 16'h0000;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            ack      <= do_access &  in_range;
            err      <= do_access & ~in_range;
            if (do_access && in_range && !wb.wb_we_i) begin
                rdata <= mem[word_idx];
            end
        end
    end

    // Byte-lane writes into the RAM array.
    always_ff @(posedge clk_i) begin
        // NOTE: the array has no reset so it maps onto block RAM; contents
        // survive rst_i and are undefined after power-up.
        if (do_access && in_range && wb.wb_we_i) begin
            if (wb.wb_sel_i[1]) mem[word_idx][15:8] <= wb.wb_dat_i[15:8];
            if (wb.wb_sel_i[0]) mem[word_idx][7:0]  <= wb.wb_dat_i[7:0];
        end
    end

    assign wb.wb_ack_o = ack;
    assign wb.wb_err_o = err;
    assign wb.wb_dat_o = rdata;

endmodule

// File: tb/tb_dmem_wb_responder.sv
// Directed bench for dmem_wb_responder: one instance with no wait states
// and one with three, sharing clock and reset.
module tb_dmem_wb_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] adr = 32'h0;
    logic [15:0] dat = 16'h0;
    logic [1:0]  sel = 2'b00;
    logic        we  = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    int          tgt = 0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dmem_wb_responder_if bus0 ();
    dmem_wb_responder_if bus1 ();

    assign bus0.wb_adr_i = adr;
    assign bus0.wb_dat_i = dat;
    assign bus0.wb_sel_i = sel;
    assign bus0.wb_we_i  = we;
    assign bus0.wb_stb_i = stb & (tgt == 0);
    assign bus0.wb_cyc_i = cyc & (tgt == 0);
    assign bus1.wb_adr_i = adr;
    assign bus1.wb_dat_i = dat;
    assign bus1.wb_sel_i = sel;
    assign bus1.wb_we_i  = we;
    assign bus1.wb_stb_i = stb & (tgt == 1);
    assign bus1.wb_cyc_i = cyc & (tgt == 1);

    dmem_wb_responder #(.DEPTH_LOG2(12), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (bus0.slave)
    );

    dmem_wb_responder #(.DEPTH_LOG2(12), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (bus1.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ack_of(int t);
        return (t == 0) ? bus0.wb_ack_o : bus1.wb_ack_o;
    endfunction

    function automatic logic err_of(int t);
        return (t == 0) ? bus0.wb_err_o : bus1.wb_err_o;
    endfunction

    function automatic logic [15:0] dat_of(int t);
        return (t == 0) ? bus0.wb_dat_o : bus1.wb_dat_o;
    endfunction

    // Drive one transaction and report the number of cycles until the
    // termination pulse (-1 on timeout) and whether it was an error.
    task automatic xfer(input int t, input logic w, input logic [31:0] a,
                        input logic [15:0] d, input logic [1:0] s,
                        output int cycles, output logic errd);
        tgt = t; we = w; adr = a; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
        cycles = -1;
        errd   = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ack_of(t) || err_of(t)) begin
                cycles = i;
                errd   = err_of(t);
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        tgt = 0; we = 1'b1; adr = 32'h10; dat = 16'hFFFF; sel = 2'b11;
        cyc = 1'b1; stb = 1'b1; rst = 1'b0;
        repeat (3) tick();
        total_cnt++; if (bus0.wb_ack_o !== 1'b0) $display("FAIL reset_ack0: got %b want 0", bus0.wb_ack_o); else pass_cnt++;
        total_cnt++; if (bus0.wb_err_o !== 1'b0) $display("FAIL reset_err0: got %b want 0", bus0.wb_err_o); else pass_cnt++;
        total_cnt++; if (bus0.wb_dat_o !== 16'h0000) $display("FAIL reset_dat0: got %h want 0000", bus0.wb_dat_o); else pass_cnt++;
        total_cnt++; if (bus1.wb_ack_o !== 1'b0) $display("FAIL reset_ack1: got %b want 0", bus1.wb_ack_o); else pass_cnt++;
        total_cnt++; if (bus1.wb_dat_o !== 16'h0000) $display("FAIL reset_dat1: got %h want 0000", bus1.wb_dat_o); else pass_cnt++;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (bus0.wb_ack_o || bus0.wb_err_o || bus1.wb_ack_o || bus1.wb_err_o) seen++;
            end
            total_cnt++; if (seen !== 0) $display("FAIL idle_no_term: got %0d pulses want 0", seen); else pass_cnt++;
        end
    endtask

    task automatic test_write_read();
        int c; logic e;
        xfer(0, 1'b1, 32'h10, 16'hA5C3, 2'b11, c, e);
        total_cnt++; if (c !== 1) $display("FAIL wr_latency: got %0d want 1", c); else pass_cnt++;
        total_cnt++; if (e !== 1'b0) $display("FAIL wr_no_err: got %b want 0", e); else pass_cnt++;
        total_cnt++; if (bus0.wb_ack_o !== 1'b0) $display("FAIL ack_single_pulse: got %b want 0", bus0.wb_ack_o); else pass_cnt++;
        xfer(0, 1'b0, 32'h10, 16'h0000, 2'b11, c, e);
        total_cnt++; if (c !== 1) $display("FAIL rd_latency: got %0d want 1", c); else pass_cnt++;
        total_cnt++; if (bus0.wb_dat_o !== 16'hA5C3) $display("FAIL rd_0x10: got %h want a5c3", bus0.wb_dat_o); else pass_cnt++;
        xfer(0, 1'b0, 32'h11, 16'h0000, 2'b01, c, e);
        total_cnt++; if (bus0.wb_dat_o !== 16'hA5C3) $display("FAIL rd_0x11: got %h want a5c3", bus0.wb_dat_o); else pass_cnt++;
    endtask

    task automatic test_lanes();
        int c; logic e;
        xfer(0, 1'b1, 32'h10, 16'h1234, 2'b01, c, e);
        xfer(0, 1'b0, 32'h10, 16'h0000, 2'b11, c, e);
        total_cnt++; if (bus0.wb_dat_o !== 16'hA534) $display("FAIL lane_low: got %h want a534", bus0.wb_dat_o); else pass_cnt++;
        xfer(0, 1'b1, 32'h10, 16'h7788, 2'b10, c, e);
        xfer(0, 1'b0, 32'h10, 16'h0000, 2'b11, c, e);
        total_cnt++; if (bus0.wb_dat_o !== 16'h7734) $display("FAIL lane_high: got %h want 7734", bus0.wb_dat_o); else pass_cnt++;
        xfer(0, 1'b1, 32'h10, 16'hFFFF, 2'b00, c, e);
        total_cnt++; if (c !== 1 || e !== 1'b0) $display("FAIL sel00_ack: got cycles=%0d err=%b want 1/0", c, e); else pass_cnt++;
        xfer(0, 1'b0, 32'h10, 16'h0000, 2'b11, c, e);
        total_cnt++; if (bus0.wb_dat_o !== 16'h7734) $display("FAIL sel00_nowrite: got %h want 7734", bus0.wb_dat_o); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int c; logic e;
        int acks = 0; int adj = 0; int first = -1; int second = -1;
        logic prev = 1'b0;
        logic a;
        tgt = 0; we = 1'b1; adr = 32'h20; dat = 16'hDEAD; sel = 2'b11;
        cyc = 1'b1; stb = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            a = bus0.wb_ack_o;
            if (a && prev) adj++;
            if (a) begin
                acks++;
                if (acks == 1) begin
                    first = i; adr = 32'h22; dat = 16'hBEEF;
                end else if (acks == 2) begin
                    second = i; cyc = 1'b0; stb = 1'b0;
                end
            end
            prev = a;
        end
        cyc = 1'b0; stb = 1'b0;
        total_cnt++; if (acks !== 2) $display("FAIL split_ack_count: got %0d want 2", acks); else pass_cnt++;
        total_cnt++; if (adj !== 0) $display("FAIL split_adjacent: got %0d want 0", adj); else pass_cnt++;
        total_cnt++; if (second - first !== 2) $display("FAIL split_spacing: got %0d want 2", second - first); else pass_cnt++;
        xfer(0, 1'b0, 32'h20, 16'h0000, 2'b11, c, e);
        total_cnt++; if (bus0.wb_dat_o !== 16'hDEAD) $display("FAIL split_hi: got %h want dead", bus0.wb_dat_o); else pass_cnt++;
        xfer(0, 1'b0, 32'h22, 16'h0000, 2'b11, c, e);
        total_cnt++; if (bus0.wb_dat_o !== 16'hBEEF) $display("FAIL split_lo: got %h want beef", bus0.wb_dat_o); else pass_cnt++;
    endtask

    task automatic test_wait_states();
        int c; logic e;
        int seen = 0;
        xfer(1, 1'b1, 32'h30, 16'hCAFE, 2'b11, c, e);
        total_cnt++; if (c !== 4) $display("FAIL ws3_wr_latency: got %0d want 4", c); else pass_cnt++;
        tgt = 1; we = 1'b1; adr = 32'h30; dat = 16'h1111; sel = 2'b11;
        cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus1.wb_ack_o || bus1.wb_err_o) seen++;
        end
        stb = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus1.wb_ack_o || bus1.wb_err_o) seen++;
        end
        cyc = 1'b0;
        total_cnt++; if (seen !== 0) $display("FAIL ws3_abort_no_term: got %0d pulses want 0", seen); else pass_cnt++;
        xfer(1, 1'b0, 32'h30, 16'h0000, 2'b11, c, e);
        total_cnt++; if (c !== 4 || e !== 1'b0) $display("FAIL ws3_rd_after_abort: got cycles=%0d err=%b want 4/0", c, e); else pass_cnt++;
        total_cnt++; if (bus1.wb_dat_o !== 16'hCAFE) $display("FAIL ws3_abort_nowrite: got %h want cafe", bus1.wb_dat_o); else pass_cnt++;
    endtask

    task automatic test_error();
        int c; logic e;
        xfer(0, 1'b1, 32'h0, 16'h0F0F, 2'b11, c, e);
        xfer(0, 1'b1, 32'h2000, 16'hBAD0, 2'b11, c, e);
        total_cnt++; if (c !== 1 || e !== 1'b1) $display("FAIL oor_wr_err: got cycles=%0d err=%b want 1/1", c, e); else pass_cnt++;
        xfer(0, 1'b0, 32'h0, 16'h0000, 2'b11, c, e);
        total_cnt++; if (bus0.wb_dat_o !== 16'h0F0F) $display("FAIL oor_no_alias: got %h want 0f0f", bus0.wb_dat_o); else pass_cnt++;
        xfer(0, 1'b0, 32'h2000, 16'h0000, 2'b11, c, e);
        total_cnt++; if (e !== 1'b1) $display("FAIL oor_rd_err: got %b want 1", e); else pass_cnt++;
        total_cnt++; if (bus0.wb_dat_o !== 16'h0F0F) $display("FAIL oor_rd_hold: got %h want 0f0f", bus0.wb_dat_o); else pass_cnt++;
        xfer(0, 1'b0, 32'hFFFF_FFFE, 16'h0000, 2'b11, c, e);
        total_cnt++; if (c !== 1 || e !== 1'b1) $display("FAIL top_addr_err: got cycles=%0d err=%b want 1/1", c, e); else pass_cnt++;
        xfer(0, 1'b0, 32'h1FFE, 16'h0000, 2'b11, c, e);
        total_cnt++; if (c !== 1 || e !== 1'b0) $display("FAIL last_word_ack: got cycles=%0d err=%b want 1/0", c, e); else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        int c; logic e;
        int seen = 0;
        tgt = 1; we = 1'b1; adr = 32'h30; dat = 16'h5555; sel = 2'b11;
        cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus1.wb_ack_o || bus1.wb_err_o) seen++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus1.wb_ack_o || bus1.wb_err_o) seen++;
        end
        total_cnt++; if (bus1.wb_dat_o !== 16'h0000) $display("FAIL midop_dat_reset: got %h want 0000", bus1.wb_dat_o); else pass_cnt++;
        cyc = 1'b0; stb = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus1.wb_ack_o || bus1.wb_err_o) seen++;
        end
        total_cnt++; if (seen !== 0) $display("FAIL midop_no_term: got %0d pulses want 0", seen); else pass_cnt++;
        xfer(1, 1'b0, 32'h30, 16'h0000, 2'b11, c, e);
        total_cnt++; if (bus1.wb_dat_o !== 16'hCAFE) $display("FAIL midop_mem_kept: got %h want cafe", bus1.wb_dat_o); else pass_cnt++;
        xfer(0, 1'b0, 32'h20, 16'h0000, 2'b11, c, e);
        total_cnt++; if (bus0.wb_dat_o !== 16'hDEAD) $display("FAIL reset_keeps_ram: got %h want dead", bus0.wb_dat_o); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_lanes();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
